// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle for uart_rx_ctrl: receiver valid/next handshake plus the
// CPU memory-mapped register port and the interrupt line.
interface uart_rx_ctrl_if;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        rx_next;
  logic        mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        irq;

  // Driver side: the receiver and the CPU.
  modport master (
    output rx_dv, rx_byte, mem_addr, mem_wen, mem_wdata,
    input  rx_next, mem_rdata, irq
  );

  // Controller side.
  modport slave (
    input  rx_dv, rx_byte, mem_addr, mem_wen, mem_wdata,
    output rx_next, mem_rdata, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: acks bytes from the receiver into a
// DEPTH-entry FIFO, exposes DATA/STATUS registers to the CPU and raises a
// level interrupt while data is pending.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter bit          DROP_ON_FULL = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  uart_rx_ctrl_if.slave bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_LOW = 1'b1
  } state_t;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  state_t        state, state_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow, irq_en, irq_q, rx_next_q;
  logic          empty, full, push, pop, drop, ack, status_wr;
  logic [31:0]   rdata;
  logic          unused_wdata;

  assign empty     = (count == '0);
  assign full      = (count == FULL_COUNT);
  assign pop       = bus.mem_wen && !bus.mem_addr && bus.mem_wdata[31] && !empty;
  assign status_wr = bus.mem_wen && bus.mem_addr;

  assign unused_wdata = ^{bus.mem_wdata[30], bus.mem_wdata[27:0]};

  // Capture FSM next state: ack once per held byte, then wait for rx_dv low.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop       = 1'b0;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_dv) begin
          if (!full) begin
            push       = 1'b1;
            ack        = 1'b1;
            state_next = WAIT_LOW;
          end else if (DROP_ON_FULL) begin
            drop       = 1'b1;
            ack        = 1'b1;
            state_next = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (!bus.rx_dv) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register and registered one-cycle ack pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_next_q <= 1'b0;
    end else begin
      state     <= state_next;
      rx_next_q <= ack;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are masked by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rx_byte;
  end

  // Overflow flag (a drop beats a same-cycle clear), irq enable and irq line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      irq_en   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (status_wr && bus.mem_wdata[29])
        overflow <= 1'b0;
      if (status_wr) irq_en <= bus.mem_wdata[28];
      irq_q <= irq_en && !empty;
    end
  end

  // Register read mux: DATA shows the head byte, STATUS the flags and count.
  always_comb begin
    rdata = '0;
    if (!bus.mem_addr) begin
      rdata[31]  = !empty;
      rdata[30]  = overflow;
      rdata[7:0] = empty ? 8'h00 : mem[rd_ptr];
    end else begin
      rdata[31]   = !empty;
      rdata[30]   = full;
      rdata[29]   = overflow;
      rdata[28]   = irq_en;
      rdata[AW:0] = count;
    end
  end

  assign bus.rx_next   = rx_next_q;
  assign bus.irq       = irq_q;
  assign bus.mem_rdata = rdata;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: one instance holds the receiver off when
// full, the other drops bytes; a byte queue holds the expected FIFO contents.
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  bit          sel;
  logic        rx_next_s, irq_s;
  logic [31:0] rdata_s;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [7:0] q[$];

  uart_rx_ctrl_if bus0 ();
  uart_rx_ctrl_if bus1 ();

  assign bus0.rx_dv     = rx_dv;
  assign bus0.rx_byte   = rx_byte;
  assign bus0.mem_addr  = mem_addr;
  assign bus0.mem_wen   = mem_wen;
  assign bus0.mem_wdata = mem_wdata;
  assign bus1.rx_dv     = rx_dv;
  assign bus1.rx_byte   = rx_byte;
  assign bus1.mem_addr  = mem_addr;
  assign bus1.mem_wen   = mem_wen;
  assign bus1.mem_wdata = mem_wdata;

  assign rx_next_s = sel ? bus1.rx_next   : bus0.rx_next;
  assign irq_s     = sel ? bus1.irq       : bus0.irq;
  assign rdata_s   = sel ? bus1.mem_rdata : bus0.mem_rdata;

  uart_rx_ctrl #(.DEPTH(16), .AW(4), .DROP_ON_FULL(1'b0)) dut_hold (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  uart_rx_ctrl #(.DEPTH(16), .AW(4), .DROP_ON_FULL(1'b1)) dut_drop (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    mem_addr = a;
    #1;
    d = rdata_s;
  endtask

  // All tasks below start and end just after a rising edge.
  task automatic wr(input logic a, input logic [31:0] d);
    mem_addr  = a;
    mem_wen   = 1'b1;
    mem_wdata = d;
    @(posedge clk); #1;
    mem_wen   = 1'b0;
    mem_wdata = '0;
  endtask

  task automatic chk_reg(input string tag, input logic a, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    rd(a, d);
    check(tag, d, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_next_s === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_hs;
    @(posedge clk); #1;
    rx_dv = 1'b0;
    @(negedge clk);
    check("ack_pulse_width", {31'b0, rx_next_s}, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep);
    int lat;
    rx_dv   = 1'b1;
    rx_byte = b;
    if (keep) q.push_back(b);
    wait_ack(6, lat);
    check("ack_latency", lat, 32'd1);
    if (lat >= 0) finish_hs;
    else rx_dv = 1'b0;
  endtask

  task automatic pop_check(input logic ovf);
    logic [31:0] d, e;
    @(negedge clk);
    rd(1'b0, d);
    if (q.size() > 0) e = {1'b1, ovf, 22'h0, q.pop_front()};
    else              e = {1'b0, ovf, 30'h0};
    check("data_head", d, e);
    wr(1'b0, 32'h8000_0000);
  endtask

  task automatic do_reset;
    logic [31:0] d;
    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    q.delete();
    @(negedge clk);
    check("rst_rx_next", {31'b0, rx_next_s}, 32'h0);
    check("rst_irq", {31'b0, irq_s}, 32'h0);
    rd(1'b0, d); check("rst_data", d, 32'h0);
    rd(1'b1, d); check("rst_status", d, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    bit seen;

    mem_addr = 1'b0;
    sel      = 1'b0;
    do_reset();

    // Single byte: ack latency, DATA valid in the ack cycle, then pop.
    rx_dv = 1'b1; rx_byte = 8'h41; q.push_back(8'h41);
    wait_ack(6, lat);
    check("single_ack_latency", lat, 32'd1);
    rd(1'b0, d);
    check("single_data_at_ack", d, 32'h8000_0041);
    finish_hs();
    chk_reg("single_status", 1'b1, 32'h8000_0001);
    pop_check(1'b0);
    chk_reg("single_data_empty", 1'b0, 32'h0);

    // Fill to DEPTH; the 17th byte is held off until a slot is freed.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    rx_dv = 1'b1; rx_byte = 8'h10; q.push_back(8'h10);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rx_next_s === 1'b1) seen = 1'b1;
    end
    check("full_no_ack", {31'b0, seen}, 32'h0);
    rd(1'b1, d);
    check("status_full", d, 32'hC000_0010);
    @(posedge clk); #1;
    pop_check(1'b0);
    wait_ack(4, lat);
    check("ack_after_pop", lat, 32'd1);
    if (lat >= 0) finish_hs();
    else rx_dv = 1'b0;
    chk_reg("status_refull", 1'b1, 32'hC000_0010);
    for (int i = 0; i < 16; i++) pop_check(1'b0);
    chk_reg("status_drained", 1'b1, 32'h0);

    // Pop on empty together with a push: push only.
    rx_dv = 1'b1; rx_byte = 8'h5A; q.push_back(8'h5A);
    mem_addr = 1'b0; mem_wen = 1'b1; mem_wdata = 32'h8000_0000;
    @(posedge clk); #1;
    mem_wen = 1'b0; mem_wdata = '0;
    @(negedge clk);
    check("empty_pp_ack", {31'b0, rx_next_s}, 32'h1);
    finish_hs();
    chk_reg("empty_pp_count", 1'b1, 32'h8000_0001);
    pop_check(1'b0);

    // Simultaneous push and pop at count 5, long enough to wrap pointers.
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rd(1'b1, d);
      check("pp_count5", d, 32'h8000_0005);
      rd(1'b0, d);
      check("pp_head", d, {1'b1, 1'b0, 22'h0, q[0]});
      void'(q.pop_front());
      rx_dv = 1'b1; rx_byte = 8'hB0 + 8'(k); q.push_back(rx_byte);
      mem_addr = 1'b0; mem_wen = 1'b1; mem_wdata = 32'h8000_0000;
      @(posedge clk); #1;
      mem_wen = 1'b0; mem_wdata = '0;
      @(negedge clk);
      check("pp_ack", {31'b0, rx_next_s}, 32'h1);
      finish_hs();
    end
    for (int i = 0; i < 5; i++) pop_check(1'b0);
    chk_reg("pp_empty", 1'b1, 32'h0);

    // Interrupt enabled: rises one cycle after not-empty, falls one after the pop.
    wr(1'b1, 32'h1000_0000);
    chk_reg("irq_en_status", 1'b1, 32'h1000_0000);
    check("irq_idle", {31'b0, irq_s}, 32'h0);
    rx_dv = 1'b1; rx_byte = 8'h33; q.push_back(8'h33);
    wait_ack(6, lat);
    check("irq_ack_latency", lat, 32'd1);
    check("irq_at_capture", {31'b0, irq_s}, 32'h0);
    @(posedge clk); #1;
    rx_dv = 1'b0;
    @(negedge clk);
    check("irq_rise", {31'b0, irq_s}, 32'h1);
    @(posedge clk); #1;
    pop_check(1'b0);
    @(negedge clk);
    check("irq_hold_after_pop", {31'b0, irq_s}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'b0, irq_s}, 32'h0);
    @(posedge clk); #1;

    // Interrupt disabled: irq stays low with data pending.
    wr(1'b1, 32'h0);
    send_byte(8'h34, 1'b1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (irq_s !== 1'b0) seen = 1'b1;
    end
    check("irq_disabled", {31'b0, seen}, 32'h0);
    @(posedge clk); #1;
    pop_check(1'b0);

    // Reset mid-stream with 3 bytes queued and a byte held on rx_dv.
    wr(1'b1, 32'h1000_0000);
    for (int i = 0; i < 3; i++) send_byte(8'h61 + 8'(i), 1'b1);
    @(negedge clk);
    check("pre_reset_irq", {31'b0, irq_s}, 32'h1);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_irq", {31'b0, irq_s}, 32'h0);
    check("async_rst_rx_next", {31'b0, rx_next_s}, 32'h0);
    rd(1'b0, d); check("async_rst_data", d, 32'h0);
    rd(1'b1, d); check("async_rst_status", d, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete();
    q.push_back(8'h77);
    wait_ack(6, lat);
    check("post_rst_ack", lat, 32'd1);
    if (lat >= 0) finish_hs();
    else rx_dv = 1'b0;
    chk_reg("post_rst_status", 1'b1, 32'h8000_0001);
    pop_check(1'b0);
    chk_reg("post_rst_empty", 1'b1, 32'h0);

    // Drop-on-full instance.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    // Drop and overflow clear in the same cycle: the set wins.
    rx_dv = 1'b1; rx_byte = 8'h99;
    mem_addr = 1'b1; mem_wen = 1'b1; mem_wdata = 32'h2000_0000;
    @(posedge clk); #1;
    mem_wen = 1'b0; mem_wdata = '0;
    @(negedge clk);
    check("drop_ack", {31'b0, rx_next_s}, 32'h1);
    finish_hs();
    chk_reg("ovf_set_wins", 1'b1, 32'hE000_0010);
    chk_reg("data_ovf_bit", 1'b0, 32'hC000_0000);
    wr(1'b1, 32'h2000_0000);
    chk_reg("ovf_cleared", 1'b1, 32'hC000_0010);
    send_byte(8'hAA, 1'b0);
    chk_reg("ovf_again", 1'b1, 32'hE000_0010);
    wr(1'b1, 32'h2000_0000);
    chk_reg("ovf_cleared2", 1'b1, 32'hC000_0010);
    for (int i = 0; i < 16; i++) pop_check(1'b0);
    chk_reg("drop_drained", 1'b1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
